tile_fill_ctrl: RTL and testbench

Hardware rectangle-fill engine for the tile display peripheral. Software programs a rectangle origin, size and tile number through a small 8-bit Avalon agent port and starts the fill. The block then requests the peripheral's shared 8-bit bus through a req/gnt handshake and issues one tilemap byte write per cycle. It sits between the CPU bridge and the tile peripheral's bus mux and removes per-cell CPU writes for screen clears and panel draws.

---
 rtl/tile_fill_ctrl_if.sv | 46 ++++
 rtl/tile_fill_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_tile_fill_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_fill_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------
// tile_fill_ctrl_if : register-agent and peripheral-bus bundles used by
//                     the tile_fill_ctrl rectangle-fill engine
// Revision: 1.0
//------------------------------------------------------------------------

// 8-bit Avalon agent port: the CPU bridge is master, the fill engine is slave.
interface tile_fill_agent_if;
  logic       s_chipselect;
  logic       s_write;
  logic [2:0] s_address;
  logic [7:0] s_writedata;
  logic [7:0] s_readdata;

  modport master (
    output s_chipselect, s_write, s_address, s_writedata,
    input  s_readdata
  );
  modport slave (
    input  s_chipselect, s_write, s_address, s_writedata,
    output s_readdata
  );
endinterface

// Shared peripheral bus: the fill engine is master behind a req/gnt mux.
interface tile_fill_bus_if;
  logic        m_req;
  logic        m_gnt;
  logic        m_chipselect;
  logic        m_write;
  logic [14:0] m_address;
  logic [7:0]  m_writedata;

  modport master (
    output m_req, m_chipselect, m_write, m_address, m_writedata,
    input  m_gnt
  );
  modport slave (
    input  m_req, m_chipselect, m_write, m_address, m_writedata,
    output m_gnt
  );
endinterface

`default_nettype wire

// File: rtl/tile_fill_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------
// tile_fill_ctrl : rectangle fill of the 128x64 tilemap, one byte write per
//                  granted cycle. Define TILE_FILL_WRAP_EN to wrap at the
//                  map edges instead of clipping.
// Revision: 1.0
//------------------------------------------------------------------------
module tile_fill_ctrl (
  input  wire logic         clk,
  input  wire logic         reset,
  tile_fill_agent_if.slave  s,
  tile_fill_bus_if.master   m,
  output logic              irq
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Programmed registers
  logic [6:0] reg_x;
  logic [5:0] reg_y;
  logic [6:0] reg_wm1;
  logic [5:0] reg_hm1;
  logic [7:0] reg_tile;
  logic       ien;
  logic       done;

  // Working copy latched at start
  logic [6:0] fill_x;
  logic [6:0] fill_wm1;
  logic [5:0] fill_hm1;
  logic [7:0] fill_tile;
  logic [6:0] ci;
  logic [5:0] rj;
  // One extra bit on col/row flags cells past the right/bottom edge
  logic [7:0] col;
  logic [6:0] row;

  logic wr;
  logic rd;
  logic ctrl_wr;
  logic start;
  logic abort;
  logic busy;
  logic last;
  logic skip;
  logic strobe;
  logic advance;

  assign wr      = s.s_chipselect & s.s_write;
  assign rd      = s.s_chipselect & ~s.s_write;
  assign ctrl_wr = wr & (s.s_address == 3'd5);
  assign start   = ctrl_wr & s.s_writedata[0];
  assign abort   = ctrl_wr & s.s_writedata[1];
  assign busy    = (state != ST_IDLE);
  assign last    = (ci == fill_wm1) && (rj == fill_hm1);
  assign advance = (state == ST_WRITE) & m.m_gnt & ~abort;

`ifdef TILE_FILL_WRAP_EN
  logic unused_ovf;
  assign unused_ovf = col[7] | row[6];
  assign skip       = 1'b0;
`else
  assign skip = col[7] | row[6];
`endif

  // A clipped cell still spends its WRITE cycle so both builds time alike
  assign strobe = (state == ST_WRITE) & m.m_gnt & ~skip;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (abort)        state_nxt = ST_IDLE;
        else if (m.m_gnt) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        if (abort)                state_nxt = ST_IDLE;
        else if (m.m_gnt && last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_x     <= '0;
      reg_y     <= '0;
      reg_wm1   <= '0;
      reg_hm1   <= '0;
      reg_tile  <= '0;
      ien       <= 1'b0;
      done      <= 1'b0;
      fill_x    <= '0;
      fill_wm1  <= '0;
      fill_hm1  <= '0;
      fill_tile <= '0;
      ci        <= '0;
      rj        <= '0;
      col       <= '0;
      row       <= '0;
    end else begin
      if (wr) begin
        case (s.s_address)
          3'd0:    reg_x    <= s.s_writedata[6:0];
          3'd1:    reg_y    <= s.s_writedata[5:0];
          3'd2:    reg_wm1  <= s.s_writedata[6:0];
          3'd3:    reg_hm1  <= s.s_writedata[5:0];
          3'd4:    reg_tile <= s.s_writedata;
          3'd5:    ien      <= s.s_writedata[2];
          default: ;
        endcase
      end

      if ((state == ST_IDLE) && start) begin
        fill_x    <= reg_x;
        fill_wm1  <= reg_wm1;
        fill_hm1  <= reg_hm1;
        fill_tile <= reg_tile;
        ci        <= '0;
        rj        <= '0;
        col       <= {1'b0, reg_x};
        row       <= {1'b0, reg_y};
        done      <= 1'b0;
      end else if (state == ST_DONE) begin
        done <= 1'b1;
      end else if (advance) begin
        if (ci == fill_wm1) begin
          ci  <= '0;
          rj  <= rj + 6'd1;
          col <= {1'b0, fill_x};
          row <= row + 7'd1;
        end else begin
          ci  <= ci + 7'd1;
          col <= col + 8'd1;
        end
      end
    end
  end

  always_comb begin
    s.s_readdata = 8'h00;
    if (rd) begin
      case (s.s_address)
        3'd0:    s.s_readdata = {1'b0, reg_x};
        3'd1:    s.s_readdata = {2'b00, reg_y};
        3'd2:    s.s_readdata = {1'b0, reg_wm1};
        3'd3:    s.s_readdata = {2'b00, reg_hm1};
        3'd4:    s.s_readdata = reg_tile;
        3'd5:    s.s_readdata = {5'b00000, ien, done, busy};
        default: s.s_readdata = 8'h00;
      endcase
    end
  end

  assign m.m_req        = (state == ST_REQ) | (state == ST_WRITE);
  assign m.m_chipselect = strobe;
  assign m.m_write      = strobe;
  assign m.m_address    = strobe ? {2'b00, row[5:0], col[6:0]} : 15'h0000;
  assign m.m_writedata  = strobe ? fill_tile : 8'h00;
  assign irq            = done & ien;

endmodule

`default_nettype wire

// File: tb/tb_tile_fill_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------
// tb_tile_fill_ctrl : directed and randomized bench for tile_fill_ctrl
// Revision: 1.0
//------------------------------------------------------------------------
module tb_tile_fill_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  tile_fill_agent_if agt();
  tile_fill_bus_if   bus();

  tile_fill_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .s     (agt.slave),
    .m     (bus.master),
    .irq   (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [14:0] seen_addr[$];
  int          seen_cyc[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: programmed registers, the latched rectangle, a phase
  // (0 idle, 1 requesting, 2 writing, 3 done) and a linear cell index.
  int px, py, pwm1, phm1, ptile, mien, mdone;
  int wx, wy, ww, wh, wt;
  int phase, k;

  task automatic model_reset();
    px = 0; py = 0; pwm1 = 0; phm1 = 0; ptile = 0; mien = 0; mdone = 0;
    wx = 0; wy = 0; ww = 1; wh = 1; wt = 0; phase = 0; k = 0;
  endtask

  initial begin
    int c, r, e_stb, e_rd, e_addr, a, d, wr;
    model_reset();
    forever begin
      @(negedge clk);
      if (reset) begin
        model_reset();
        chk("rst_m_req", bus.m_req, 0);
        chk("rst_m_cs", bus.m_chipselect, 0);
        chk("rst_m_addr", bus.m_address, 0);
        chk("rst_readdata", agt.s_readdata, 0);
        chk("rst_irq", irq, 0);
      end else begin
        e_stb = 0; e_addr = 0;
        if (phase == 2) begin
          c = wx + (k % ww);
          r = wy + (k / ww);
`ifdef TILE_FILL_WRAP_EN
          e_stb = bus.m_gnt;
`else
          e_stb = (bus.m_gnt && c <= 127 && r <= 63) ? 1 : 0;
`endif
          e_addr = ((r % 64) * 128) + (c % 128);
        end
        e_rd = 0;
        if (agt.s_chipselect && !agt.s_write) begin
          case (agt.s_address)
            3'd0: e_rd = px;
            3'd1: e_rd = py;
            3'd2: e_rd = pwm1;
            3'd3: e_rd = phm1;
            3'd4: e_rd = ptile;
            3'd5: e_rd = mien * 4 + mdone * 2 + ((phase != 0) ? 1 : 0);
            default: e_rd = 0;
          endcase
        end
        chk("m_req", bus.m_req, (phase == 1 || phase == 2) ? 1 : 0);
        chk("m_chipselect", bus.m_chipselect, e_stb);
        chk("m_write", bus.m_write, e_stb);
        if (e_stb != 0) begin
          chk("m_address", bus.m_address, e_addr);
          chk("m_writedata", bus.m_writedata, wt);
        end
        chk("irq", irq, mdone & mien);
        chk("s_readdata", agt.s_readdata, e_rd);
        if (bus.m_chipselect) begin
          seen_addr.push_back(bus.m_address);
          seen_cyc.push_back(cyc);
        end

        // advance the model across the coming edge
        wr = (agt.s_chipselect && agt.s_write) ? 1 : 0;
        a  = agt.s_address;
        d  = agt.s_writedata;
        if (phase == 0) begin
          if (wr && a == 5 && d[0]) begin
            wx = px; wy = py; ww = pwm1 + 1; wh = phm1 + 1; wt = ptile;
            mdone = 0; phase = 1; k = 0;
          end
        end else if (phase == 3) begin
          phase = 0; mdone = 1;
        end else if (wr && a == 5 && d[1]) begin
          phase = 0;
        end else if (phase == 1) begin
          if (bus.m_gnt) phase = 2;
        end else if (bus.m_gnt) begin
          if (k == ww * wh - 1) phase = 3;
          else k++;
        end
        if (wr) begin
          case (a)
            0: px    = d % 128;
            1: py    = d % 64;
            2: pwm1  = d % 128;
            3: phm1  = d % 64;
            4: ptile = d;
            5: mien  = d[2];
            default: ;
          endcase
        end
      end
    end
  end

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    agt.s_chipselect = 1'b1; agt.s_write = 1'b1;
    agt.s_address = a; agt.s_writedata = d;
    @(posedge clk); #1;
    agt.s_chipselect = 1'b1; agt.s_write = 1'b0; agt.s_address = 3'd5;
  endtask

  task automatic prog(input int x, input int y, input int wm1, input int hm1, input int t);
    cpu_write(3'd0, 8'(x));
    cpu_write(3'd1, 8'(y));
    cpu_write(3'd2, 8'(wm1));
    cpu_write(3'd3, 8'(hm1));
    cpu_write(3'd4, 8'(t));
  endtask

  task automatic wait_idle(output int c);
    int b;
    b = 0; c = -1;
    while (b < 3000) begin
      @(negedge clk);
      b++;
      if (agt.s_readdata[0] == 1'b0) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("idle_wait_timeout", 0, 1);
  endtask

  task automatic wait_strobes(input int n);
    int got, b;
    got = 0; b = 0;
    while (got < n && b < 500) begin
      @(negedge clk);
      b++;
      if (bus.m_chipselect) got++;
    end
    if (got < n) chk("strobe_wait_timeout", got, n);
  endtask

  initial begin
    int c0, c, n0, ok, r;
    agt.s_chipselect = 1'b0; agt.s_write = 1'b0;
    agt.s_address = 3'd0; agt.s_writedata = 8'h00;
    bus.m_gnt = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    bus.m_gnt = 1'b1;

    // 4x2 fill with grant held high
    prog(10, 5, 3, 1, 8'h41);
    n0 = seen_addr.size();
    cpu_write(3'd5, 8'h01);
    c0 = cyc;
    wait_idle(c);
    chk("t1_idle_cycle", c - c0, 10);
    chk("t1_done_bit", agt.s_readdata[1], 1);
    #1;
    chk("t1_strobes", seen_addr.size() - n0, 8);
    chk("t1_first_addr", seen_addr[n0], 15'h028A);
    chk("t1_first_cycle", seen_cyc[n0] - c0, 1);
    chk("t1_4th_addr", seen_addr[n0 + 3], 15'h028D);
    chk("t1_5th_addr", seen_addr[n0 + 4], 15'h030A);
    chk("t1_last_addr", seen_addr[n0 + 7], 15'h030D);
    chk("t1_last_cycle", seen_cyc[n0 + 7] - c0, 8);

    // same fill, grant dropped for 3 cycles after the 3rd strobe
    n0 = seen_addr.size();
    cpu_write(3'd5, 8'h01);
    c0 = cyc;
    wait_strobes(3);
    @(posedge clk); #1 bus.m_gnt = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.m_gnt = 1'b1;
    wait_idle(c);
    chk("t2_idle_cycle", c - c0, 13);
    #1;
    chk("t2_strobes", seen_addr.size() - n0, 8);
    ok = 1;
    for (int i = 1; i < 8 && n0 + i < seen_addr.size(); i++)
      if (seen_addr[n0 + i] <= seen_addr[n0 + i - 1]) ok = 0;
    chk("t2_no_repeat", ok, 1);

    // right-edge rectangle
    prog(126, 0, 3, 0, 8'h7E);
    n0 = seen_addr.size();
    cpu_write(3'd5, 8'h01);
    c0 = cyc;
    wait_idle(c);
    chk("t3_idle_cycle", c - c0, 6);
    #1;
`ifdef TILE_FILL_WRAP_EN
    chk("t3_strobes", seen_addr.size() - n0, 4);
`else
    chk("t3_strobes", seen_addr.size() - n0, 2);
`endif
    chk("t3_col126", seen_addr[n0], 15'h007E);
    chk("t3_col127", seen_addr[n0 + 1], 15'h007F);

    // abort after two strobes
    prog(10, 5, 3, 1, 8'h55);
    n0 = seen_addr.size();
    cpu_write(3'd5, 8'h01);
    wait_strobes(2);
    @(posedge clk); #1;
    bus.m_gnt = 1'b0;
    agt.s_chipselect = 1'b1; agt.s_write = 1'b1;
    agt.s_address = 3'd5; agt.s_writedata = 8'h02;
    @(posedge clk); #1;
    agt.s_write = 1'b0; agt.s_address = 3'd5;
    bus.m_gnt = 1'b1;
    @(negedge clk);
    chk("t4_busy", agt.s_readdata[0], 0);
    chk("t4_done", agt.s_readdata[1], 0);
    chk("t4_m_req", bus.m_req, 0);
    repeat (6) @(negedge clk);
    #1;
    chk("t4_strobes", seen_addr.size() - n0, 2);

    // restart mid-fill is ignored, X takes the new value
    prog(10, 5, 3, 1, 8'h33);
    n0 = seen_addr.size();
    cpu_write(3'd5, 8'h01);
    wait_strobes(2);
    cpu_write(3'd0, 8'd50);
    cpu_write(3'd5, 8'h01);
    wait_idle(c);
    #1;
    chk("t5_strobes", seen_addr.size() - n0, 8);
    chk("t5_last_addr", seen_addr[seen_addr.size() - 1], 15'h030D);
    @(posedge clk); #1 agt.s_address = 3'd0;
    @(negedge clk);
    chk("t5_x_readback", agt.s_readdata, 50);
    #1 agt.s_address = 3'd5;

    // interrupt on a 1x1 fill
    prog(3, 4, 0, 0, 8'h11);
    cpu_write(3'd5, 8'h05);
    c0 = cyc;
    wait_idle(c);
    chk("t6_idle_cycle", c - c0, 3);
    chk("t6_irq_rise", irq, 1);
    repeat (3) @(negedge clk);
    chk("t6_irq_hold", irq, 1);
    cpu_write(3'd5, 8'h05);
    @(negedge clk);
    chk("t6_irq_clear", irq, 0);
    wait_idle(c);

    // asynchronous reset mid-fill
    prog(0, 0, 15, 3, 8'h22);
    cpu_write(3'd5, 8'h01);
    wait_strobes(3);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    chk("t7_m_req", bus.m_req, 0);
    chk("t7_m_cs", bus.m_chipselect, 0);
    chk("t7_m_write", bus.m_write, 0);
    chk("t7_readdata", agt.s_readdata, 0);
    @(posedge clk); #1 reset = 1'b0;

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      bus.m_gnt = (($urandom % 4) != 0);
      r = $urandom % 100;
      agt.s_writedata = 8'($urandom);
      if (r < 12) begin
        agt.s_chipselect = 1'b1; agt.s_write = 1'b1;
        agt.s_address = 3'($urandom % 5);
        if (agt.s_address == 3'd2) agt.s_writedata = agt.s_writedata & 8'h0F;
        if (agt.s_address == 3'd3) agt.s_writedata = agt.s_writedata & 8'h07;
      end else if (r < 18) begin
        agt.s_chipselect = 1'b1; agt.s_write = 1'b1; agt.s_address = 3'd5;
        agt.s_writedata[0] = 1'b1;
        agt.s_writedata[1] = (($urandom % 6) == 0);
      end else if (r < 20) begin
        agt.s_chipselect = 1'b1; agt.s_write = 1'b1;
        agt.s_address = 3'(6 + ($urandom % 2));
      end else begin
        agt.s_chipselect = 1'($urandom % 2); agt.s_write = 1'b0;
        agt.s_address = 3'($urandom % 8);
      end
    end
    @(posedge clk); #1;
    agt.s_chipselect = 1'b1; agt.s_write = 1'b0; agt.s_address = 3'd5;
    bus.m_gnt = 1'b1;
    wait_idle(c);
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
